// File: rtl/reload_counter_param.sv
// reload_counter_param: self-reloading up/down counter with a programmable
// reload value and up-count limit. Emits a registered one-cycle wrap pulse on
// every reload. Optional saturating reload-event counter is built when the
// macro RLC_WRAP_CNT_EN is defined; otherwise wrap_cnt_o does not exist.
module reload_counter_param #(
  parameter int WIDTH      = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  input  logic [WIDTH-1:0]      limit_i,
  output logic [WIDTH-1:0]      count_o,
`ifdef RLC_WRAP_CNT_EN
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
`endif
  output logic                  tc_o,
  output logic                  wrap_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Reject configurations the counter cannot support
  if (WIDTH < 2 || WRAP_CNT_W < 1) begin : g_param_check
    $error("reload_counter_param: WIDTH must be >= 2 and WRAP_CNT_W >= 1");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] limit_q;
  logic             wrap_q;
  logic             tc;
  logic             reload_evt;

  // Terminal detect: up compares against the limit (count may already be
  // above it after a load), down terminates at zero
  always_comb begin
    tc = 1'b0;
    if (dir_i) begin
      tc = (count_q == ZERO);
    end else begin
      tc = (count_q >= limit_q);
    end
  end

  // A reload happens only on an enabled edge that is not overridden by a load
  assign reload_evt = en_i & ~load_i & tc;

  // Count, stored reload value, limit and wrap pulse; reset > load > en > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= ZERO;
      reload_q <= ZERO;
      limit_q  <= ONES;
      wrap_q   <= 1'b0;
    end else if (load_i) begin
      count_q  <= load_val_i;
      reload_q <= load_val_i;
      limit_q  <= limit_i;
      wrap_q   <= 1'b0;
    end else if (en_i) begin
      if (tc) begin
        count_q <= reload_q;
        wrap_q  <= 1'b1;
      end else if (dir_i) begin
        count_q <= count_q - ONE;
        wrap_q  <= 1'b0;
      end else begin
        count_q <= count_q + ONE;
        wrap_q  <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

`ifdef RLC_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  // Saturating increment: holds at all ones instead of rolling over
  function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] v);
    logic [WRAP_CNT_W-1:0] r;
    r = v;
    if (v != {WRAP_CNT_W{1'b1}}) begin
      r = v + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Reload-event counter; only reset clears it, loads leave it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt_q <= {WRAP_CNT_W{1'b0}};
    end else if (reload_evt) begin
      wrap_cnt_q <= sat_inc(wrap_cnt_q);
    end else begin
      wrap_cnt_q <= wrap_cnt_q;
    end
  end

  assign wrap_cnt_o = wrap_cnt_q;
`endif

  assign count_o = count_q;
  assign tc_o    = tc;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_reload_counter_param.sv
// Directed self-checking bench for reload_counter_param (WIDTH=8).
// The wrap-event counter scenario runs only when RLC_WRAP_CNT_EN is defined.
module tb_reload_counter_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic       dir_i;
  logic       load_i;
  logic [7:0] load_val_i;
  logic [7:0] limit_i;
  logic [7:0] count_o;
  logic       tc_o;
  logic       wrap_o;
`ifdef RLC_WRAP_CNT_EN
  logic [1:0] wrap_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reload_counter_param #(.WIDTH(8), .WRAP_CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .limit_i    (limit_i),
    .count_o    (count_o),
`ifdef RLC_WRAP_CNT_EN
    .wrap_cnt_o (wrap_cnt_o),
`endif
    .tc_o       (tc_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] lim);
    load_i = 1'b1; load_val_i = v; limit_i = lim;
    step();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_i = 1'b1; dir_i = 1'b0; load_i = 1'b1;
    load_val_i = 8'h77; limit_i = 8'h01;
    step(); step();
    reset = 1'b0; load_i = 1'b0; en_i = 1'b0;
    #1;
    n_checks++; if (count_o !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", count_o); end
    n_checks++; if (wrap_o !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap_o); end
    n_checks++; if (tc_o !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc_o); end
  endtask

  task automatic test_up_reload();
    logic [7:0] exp_c [8] = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic       exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'h10, 8'h13);
    n_checks++; if (count_o !== 8'h10 || wrap_o !== 1'b0) begin n_fail++; $display("FAIL up_load: got %h/%b want 10/0", count_o, wrap_o); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (count_o !== exp_c[i] || wrap_o !== exp_w[i] || tc_o !== exp_t[i]) begin
        n_fail++;
        $display("FAIL up_seq[%0d]: got c=%h w=%b t=%b want c=%h w=%b t=%b", i, count_o, wrap_o, tc_o, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_down_reload();
    logic [7:0] exp_c [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    logic       exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dir_i = 1'b1; en_i = 1'b1;
    do_load(8'h03, 8'h13);
    n_checks++; if (count_o !== 8'h03 || tc_o !== 1'b0) begin n_fail++; $display("FAIL down_load: got %h/%b want 03/0", count_o, tc_o); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (count_o !== exp_c[i] || wrap_o !== exp_w[i] || tc_o !== exp_t[i]) begin
        n_fail++;
        $display("FAIL down_seq[%0d]: got c=%h w=%b t=%b want c=%h w=%b t=%b", i, count_o, wrap_o, tc_o, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'h10, 8'h13);
    step(); step(); step();
    n_checks++; if (count_o !== 8'h13 || tc_o !== 1'b1) begin n_fail++; $display("FAIL prio_at_tc: got %h/%b want 13/1", count_o, tc_o); end
    do_load(8'h50, 8'h13);
    n_checks++; if (count_o !== 8'h50 || wrap_o !== 1'b0) begin n_fail++; $display("FAIL prio_load_wins: got %h/%b want 50/0", count_o, wrap_o); end
    n_checks++; if (tc_o !== 1'b1) begin n_fail++; $display("FAIL above_limit_tc: got %b want 1", tc_o); end
    step();
    n_checks++; if (count_o !== 8'h50 || wrap_o !== 1'b1) begin n_fail++; $display("FAIL above_limit_reload1: got %h/%b want 50/1", count_o, wrap_o); end
    step();
    n_checks++; if (count_o !== 8'h50 || wrap_o !== 1'b1) begin n_fail++; $display("FAIL above_limit_reload2: got %h/%b want 50/1", count_o, wrap_o); end
  endtask

  task automatic test_enable_hold();
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'h10, 8'h13);
    step(); step();
    n_checks++; if (count_o !== 8'h12) begin n_fail++; $display("FAIL hold_pre: got %h want 12", count_o); end
    en_i = 1'b0;
    step(); step();
    n_checks++; if (count_o !== 8'h12 || wrap_o !== 1'b0) begin n_fail++; $display("FAIL hold_en0: got %h/%b want 12/0", count_o, wrap_o); end
    en_i = 1'b1;
    step();
    n_checks++; if (count_o !== 8'h13 || wrap_o !== 1'b0 || tc_o !== 1'b1) begin n_fail++; $display("FAIL hold_resume: got %h/%b/%b want 13/0/1", count_o, wrap_o, tc_o); end
    en_i = 1'b0;
    step();
    n_checks++; if (count_o !== 8'h13 || wrap_o !== 1'b0) begin n_fail++; $display("FAIL hold_at_tc: got %h/%b want 13/0", count_o, wrap_o); end
  endtask

  task automatic test_full_limit_and_dir();
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'hFE, 8'hFF);
    step();
    n_checks++; if (count_o !== 8'hFF || tc_o !== 1'b1) begin n_fail++; $display("FAIL ff_top: got %h/%b want ff/1", count_o, tc_o); end
    step();
    n_checks++; if (count_o !== 8'hFE || wrap_o !== 1'b1) begin n_fail++; $display("FAIL ff_reload: got %h/%b want fe/1", count_o, wrap_o); end
    dir_i = 1'b1;
    #1;
    n_checks++; if (tc_o !== 1'b0) begin n_fail++; $display("FAIL dir_tc: got %b want 0", tc_o); end
    step();
    n_checks++; if (count_o !== 8'hFD || wrap_o !== 1'b0) begin n_fail++; $display("FAIL dir_down: got %h/%b want fd/0", count_o, wrap_o); end
  endtask

  task automatic test_reset_mid();
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'h50, 8'h60);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (count_o !== 8'h00 || wrap_o !== 1'b0 || tc_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got %h/%b/%b want 00/0/0", count_o, wrap_o, tc_o); end
    step();
    n_checks++; if (count_o !== 8'h01) begin n_fail++; $display("FAIL mid_reset_count: got %h want 01", count_o); end
    en_i = 1'b0;
  endtask

`ifdef RLC_WRAP_CNT_EN
  task automatic test_wrap_cnt();
    logic [1:0] exp_n [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (wrap_cnt_o !== 2'd0) begin n_fail++; $display("FAIL wcnt_reset: got %0d want 0", wrap_cnt_o); end
    dir_i = 1'b0; en_i = 1'b1;
    do_load(8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (wrap_cnt_o !== exp_n[i] || wrap_o !== 1'b1) begin
        n_fail++;
        $display("FAIL wcnt_seq[%0d]: got %0d/%b want %0d/1", i, wrap_cnt_o, wrap_o, exp_n[i]);
      end
    end
    do_load(8'h05, 8'h10);
    n_checks++; if (wrap_cnt_o !== 2'd3) begin n_fail++; $display("FAIL wcnt_load: got %0d want 3", wrap_cnt_o); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (wrap_cnt_o !== 2'd0) begin n_fail++; $display("FAIL wcnt_clear: got %0d want 0", wrap_cnt_o); end
    en_i = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; en_i = 1'b0; dir_i = 1'b0; load_i = 1'b0;
    load_val_i = 8'h00; limit_i = 8'h00;
    #2;
    test_reset();
    test_up_reload();
    test_down_reload();
    test_load_priority();
    test_enable_hold();
    test_full_limit_and_dir();
    test_reset_mid();
`ifdef RLC_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
